button_debouncer: RTL and testbench

Input conditioner that sits directly upstream of the lab flip-flop stages. It takes a raw, asynchronous, bouncing push-button or switch signal, synchronizes it to `CLK`, and filters it. It then drives a clean, glitch-free level `D_OUT` that feeds a flip-flop's `D` input. Optional single-cycle edge pulses let downstream counters and shift registers step once per press.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/button_debouncer_sync_2ff.sv | 24 ++
 rtl/button_debouncer.sv | 132 +++++++++++++
 tb/tb_button_debouncer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encodings and default
// stability window.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b11,
    WAIT_LO = 2'b10
  } state_t;

  // 1 ms at 50 MHz
  localparam int STABLE_CNT_DEFAULT = 50000;
  localparam int CNT_W_DEFAULT      = 16;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the CLK domain.
module sync_2ff (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic sync1;
  logic sync2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= D;
      sync2 <= sync1;
    end
  end

  assign Q = sync2;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button level into a clean registered D_OUT with optional
// one-cycle RISE/FALL pulses (enabled by BUTTON_DEBOUNCER_EDGE_PULSE_EN).
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_IN,
  output logic D_OUT,
  output logic RISE,
  output logic FALL
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (STABLE_CNT < 2) begin : g_bad_stable_cnt
      $error("STABLE_CNT must be at least 2");
    end
    if ((64'd1 << CNT_W) < 64'(STABLE_CNT)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for STABLE_CNT");
    end
  endgenerate

  logic             sync2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             d_out_nxt;

  sync_2ff u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (BTN_IN),
    .Q     (sync2)
  );

  // Stage p0: FSM state, stability counter and debounced level
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE_LO;
      cnt   <= '0;
      D_OUT <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      D_OUT <= d_out_nxt;
    end
  end

  // A mismatch clearing on the commit edge wins over the commit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_out_nxt = D_OUT;
    case (state)
      IDLE_LO: begin
        if (sync2) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync2) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
          d_out_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync2) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (sync2) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
          d_out_nxt = 1'b0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LO;
        cnt_nxt   = '0;
        d_out_nxt = 1'b0;
      end
    endcase
  end

`ifdef BUTTON_DEBOUNCER_EDGE_PULSE_EN
  logic rise_nxt;
  logic fall_nxt;

  assign rise_nxt = d_out_nxt & ~D_OUT;
  assign fall_nxt = ~d_out_nxt & D_OUT;

  // Stage p1: edge pulses aligned with the D_OUT change
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RISE <= 1'b0;
      FALL <= 1'b0;
    end else begin
      RISE <= rise_nxt;
      FALL <= fall_nxt;
    end
  end
`else
  assign RISE = 1'b0;
  assign FALL = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CNT=4; pulse expectations
// follow whether BUTTON_DEBOUNCER_EDGE_PULSE_EN is defined.
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int STABLE_CNT = 4;
  localparam int CNT_W      = 3;
`ifdef BUTTON_DEBOUNCER_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic CLK    = 1'b0;
  logic RST_N  = 1'b1;
  logic BTN_IN = 1'b0;
  logic D_OUT;
  logic RISE;
  logic FALL;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  button_debouncer #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .BTN_IN (BTN_IN),
    .D_OUT  (D_OUT),
    .RISE   (RISE),
    .FALL   (FALL)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    RST_N  = 1'b0;
    BTN_IN = 1'b1;
    #1;
    n_tests++;
    if ({D_OUT, RISE, FALL} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: d/r/f=%b expected 000", {D_OUT, RISE, FALL});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if ({D_OUT, RISE, FALL} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: d/r/f=%b expected 000", i, {D_OUT, RISE, FALL});
      end
    end
    BTN_IN = 1'b0;
    tick();
    RST_N = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_clean_press();
    BTN_IN = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      logic exp_d, exp_r;
      tick();
      exp_d = (k >= 5);
      exp_r = PULSE_EN && (k == 5);
      n_tests++;
      if ({D_OUT, RISE, FALL} !== {exp_d, exp_r, 1'b0}) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: d/r/f=%b expected %b", k,
                 {D_OUT, RISE, FALL}, {exp_d, exp_r, 1'b0});
      end
    end
  endtask

  task automatic test_release();
    BTN_IN = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      logic exp_d, exp_f;
      tick();
      exp_d = (k < 5);
      exp_f = PULSE_EN && (k == 5);
      n_tests++;
      if ({D_OUT, RISE, FALL} !== {exp_d, 1'b0, exp_f}) begin
        n_fail++;
        $display("FAIL release edge %0d: d/r/f=%b expected %b", k,
                 {D_OUT, RISE, FALL}, {exp_d, 1'b0, exp_f});
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    pattern = 4'b1010;
    for (int p = 3; p >= 0; p--) begin
      BTN_IN = pattern[p];
      repeat (2) begin
        tick();
        n_tests++;
        if ({D_OUT, RISE, FALL} !== 3'b000) begin
          n_fail++;
          $display("FAIL bounce phase %0d: d/r/f=%b expected 000", 3 - p, {D_OUT, RISE, FALL});
        end
      end
    end
    BTN_IN = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      logic exp_d, exp_r;
      tick();
      exp_d = (k >= 5);
      exp_r = PULSE_EN && (k == 5);
      n_tests++;
      if ({D_OUT, RISE, FALL} !== {exp_d, exp_r, 1'b0}) begin
        n_fail++;
        $display("FAIL bounce_settle edge %0d: d/r/f=%b expected %b", k,
                 {D_OUT, RISE, FALL}, {exp_d, exp_r, 1'b0});
      end
    end
  endtask

  // Three high samples, one low sample landing on the would-be commit edge, then return.
  task automatic test_glitch_threshold();
    BTN_IN = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      logic exp_d, exp_r;
      tick();
      exp_d = (k >= 9);
      exp_r = PULSE_EN && (k == 9);
      n_tests++;
      if ({D_OUT, RISE, FALL} !== {exp_d, exp_r, 1'b0}) begin
        n_fail++;
        $display("FAIL glitch edge %0d: d/r/f=%b expected %b", k,
                 {D_OUT, RISE, FALL}, {exp_d, exp_r, 1'b0});
      end
      if (k == 2) BTN_IN = 1'b0;
      if (k == 3) BTN_IN = 1'b1;
    end
  endtask

  task automatic test_reset_from_high();
    tick();
    n_tests++;
    if (D_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_high_pre: d_out=%b expected 1", D_OUT);
    end
    #1;
    RST_N = 1'b0;
    #1;
    n_tests++;
    if ({D_OUT, RISE, FALL} !== 3'b000 || dut.state !== IDLE_LO) begin
      n_fail++;
      $display("FAIL reset_high_async: d/r/f=%b state=%b expected 000 state=00",
               {D_OUT, RISE, FALL}, dut.state);
    end
    BTN_IN = 1'b0;
    tick();
    RST_N = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset_midcount();
    BTN_IN = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (dut.state !== WAIT_HI || dut.cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL midcount_pre: state=%b cnt=%0d expected state=01 cnt=2", dut.state, dut.cnt);
    end
    #1;
    RST_N = 1'b0;
    #1;
    n_tests++;
    if (dut.state !== IDLE_LO || dut.cnt !== 3'd0 || D_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL midcount_reset: state=%b cnt=%0d d=%b expected state=00 cnt=0 d=0",
               dut.state, dut.cnt, D_OUT);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if ({D_OUT, RISE, FALL} !== 3'b000) begin
        n_fail++;
        $display("FAIL midcount_hold[%0d]: d/r/f=%b expected 000", i, {D_OUT, RISE, FALL});
      end
    end
    RST_N = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      logic exp_d, exp_r;
      tick();
      exp_d = (k >= 5);
      exp_r = PULSE_EN && (k == 5);
      n_tests++;
      if ({D_OUT, RISE, FALL} !== {exp_d, exp_r, 1'b0}) begin
        n_fail++;
        $display("FAIL post_reset_press edge %0d: d/r/f=%b expected %b", k,
                 {D_OUT, RISE, FALL}, {exp_d, exp_r, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    BTN_IN = 1'b0;
    repeat (8) tick();
    test_glitch_threshold();
    test_reset_from_high();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
